// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the GPP16 memory port arbiter, its requesters and the data memory.
// The slave modport is the arbiter's view of the bus. The master modport is the environment's view.
interface mem_port_arbiter_if #(
  parameter int N_REQ = 3,
  parameter int AW    = 16,
  parameter int DW    = 16
);
  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    req_we;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    gnt;
  logic [N_REQ-1:0]    ack;
  logic [DW-1:0]       rdata;
  logic                mem_en;
  logic                mem_we;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic [DW-1:0]       mem_rdata;
  logic                busy;

  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, ack, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter with a fixed wait-state access and a one-cycle ack.
// Define MEM_ARB_RR_EN for round-robin arbitration. The default is fixed priority, where index 0 wins.
module mem_port_arbiter #(
  parameter int N_REQ    = 3,
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int MEM_WAIT = 1
) (
  input logic              clk,
  input logic              init,
  mem_port_arbiter_if.slave bus
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t           state;
  logic [N_REQ-1:0] gnt_q, ack_q, mask;
  logic [DW-1:0]    rdata_q, wdata_q;
  logic [AW-1:0]    addr_q;
  logic             en_q, we_q, busy_q;
  logic [3:0]       cnt;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    start;

  logic [N_REQ-1:0] avail;
  logic             win_found;
  logic [IW-1:0]    win;
  logic             sel_we;
  logic [AW-1:0]    sel_addr;
  logic [DW-1:0]    sel_wdata;

  // First set bit of v, searching upward from start and wrapping at N_REQ.
  function automatic logic [IW-1:0] pick(input logic [N_REQ-1:0] v, input logic [IW-1:0] start_idx);
    logic [IW-1:0] w;
    logic          found;
    int            idx;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = int'(start_idx) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && v[IW'(idx)]) begin
        found = 1'b1;
        w     = IW'(idx);
      end
    end
    return w;
  endfunction

`ifdef MEM_ARB_RR_EN
  logic [IW-1:0] ptr;
  assign start = ptr;
`else
  assign start = '0;
`endif

  always_comb begin
    avail     = bus.req & ~mask;
    win_found = |avail;
    win       = pick(avail, start);
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (win == IW'(k)) begin
        sel_we    = bus.req_we[k];
        sel_addr  = bus.req_addr[k*AW +: AW];
        sel_wdata = bus.req_wdata[k*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (init) begin
      state   <= IDLE;
      gnt_q   <= '0;
      ack_q   <= '0;
      mask    <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      cnt     <= '0;
      owner   <= '0;
`ifdef MEM_ARB_RR_EN
      ptr     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // The previous owner is masked for one IDLE cycle only, so it can win again right after.
          mask <= '0;
          if (win_found) begin
            owner   <= win;
            gnt_q   <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            en_q    <= 1'b1;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt     <= 4'(MEM_WAIT);
            busy_q  <= 1'b1;
            state   <= ACCESS;
`ifdef MEM_ARB_RR_EN
            ptr     <= (win == IW'(N_REQ-1)) ? '0 : win + 1'b1;
`endif
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!we_q) rdata_q <= bus.mem_rdata;
            ack_q <= gnt_q;
            gnt_q <= '0;
            en_q  <= 1'b0;
            we_q  <= 1'b0;
            state <= DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE: begin
          ack_q  <= '0;
          mask   <= {{(N_REQ-1){1'b0}}, 1'b1} << owner;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_en    = en_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter, with one instance at MEM_WAIT=1 and one at MEM_WAIT=0.
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
  logic clk;
  logic init;
  int   vectors;
  int   miscompares;
  logic [2:0] exp_order [6];

  mem_port_arbiter_if #(.N_REQ(3), .AW(16), .DW(16)) i0 ();
  mem_port_arbiter_if #(.N_REQ(3), .AW(16), .DW(16)) i1 ();

  mem_port_arbiter #(.N_REQ(3), .AW(16), .DW(16), .MEM_WAIT(1)) u0 (
    .clk  (clk),
    .init (init),
    .bus  (i0.slave)
  );

  mem_port_arbiter #(.N_REQ(3), .AW(16), .DW(16), .MEM_WAIT(0)) u1 (
    .clk  (clk),
    .init (init),
    .bus  (i1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    vectors = 0;
    miscompares = 0;
    init = 1'b1;
    i0.req = '0; i0.req_we = '0; i0.req_addr = '0; i0.req_wdata = '0; i0.mem_rdata = '0;
    i1.req = '0; i1.req_we = '0; i1.req_addr = '0; i1.req_wdata = '0; i1.mem_rdata = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_gnt", i0.gnt, 3'b000);
    chk("rst_ack", i0.ack, 3'b000);
    chk("rst_en", i0.mem_en, 1'b0);
    chk("rst_busy", i0.busy, 1'b0);
    chk("rst_rdata", i0.rdata, 16'h0000);
    init = 1'b0;
    @(negedge clk);

    // Test 1: read by requester 0
    i0.req = 3'b001; i0.req_we = 3'b000;
    i0.req_addr = {16'h0000, 16'h0000, 16'h0040};
    i0.mem_rdata = 16'hBEEF;
    @(negedge clk);
    i0.req = 3'b000;
    chk("t1_gnt_c1", i0.gnt, 3'b001);
    chk("t1_en_c1", i0.mem_en, 1'b1);
    chk("t1_we", i0.mem_we, 1'b0);
    chk("t1_addr", i0.mem_addr, 16'h0040);
    chk("t1_busy", i0.busy, 1'b1);
    @(negedge clk);
    chk("t1_gnt_c2", i0.gnt, 3'b001);
    chk("t1_ack_early", i0.ack, 3'b000);
    @(negedge clk);
    chk("t1_ack", i0.ack, 3'b001);
    chk("t1_gnt_off", i0.gnt, 3'b000);
    chk("t1_rdata", i0.rdata, 16'hBEEF);
    chk("t1_busy_done", i0.busy, 1'b1);
    @(negedge clk);
    chk("t1_ack_off", i0.ack, 3'b000);
    chk("t1_busy_idle", i0.busy, 1'b0);

    // Test 2: write by requester 1, so rdata must keep its previous value
    i0.req = 3'b010; i0.req_we = 3'b010;
    i0.req_addr = {16'h0000, 16'h1234, 16'h0000};
    i0.req_wdata = {16'h0000, 16'h00A5, 16'h0000};
    i0.mem_rdata = 16'h5555;
    @(negedge clk);
    i0.req = 3'b000;
    chk("t2_gnt", i0.gnt, 3'b010);
    chk("t2_we_c1", i0.mem_we, 1'b1);
    chk("t2_addr_c1", i0.mem_addr, 16'h1234);
    chk("t2_wdata_c1", i0.mem_wdata, 16'h00A5);
    i0.req_addr = '0; i0.req_wdata = '0;
    @(negedge clk);
    chk("t2_we_c2", i0.mem_we, 1'b1);
    chk("t2_addr_c2", i0.mem_addr, 16'h1234);
    chk("t2_wdata_c2", i0.mem_wdata, 16'h00A5);
    @(negedge clk);
    chk("t2_ack", i0.ack, 3'b010);
    chk("t2_rdata_kept", i0.rdata, 16'hBEEF);
    chk("t2_we_off", i0.mem_we, 1'b0);
    @(negedge clk);

    // Test 3: requesters 0 and 2 together, then masking of the previous owner
    i0.req = 3'b101; i0.req_we = 3'b000;
    i0.req_addr = {16'h0200, 16'h0000, 16'h0100};
    i0.mem_rdata = 16'h1111;
    @(negedge clk);
    chk("t3_gnt0", i0.gnt, 3'b001);
    chk("t3_addr0", i0.mem_addr, 16'h0100);
    @(negedge clk);
    @(negedge clk);
    chk("t3_ack0", i0.ack, 3'b001);
    @(negedge clk);
    chk("t3_idle_gnt", i0.gnt, 3'b000);
    @(negedge clk);
    chk("t3_gnt2", i0.gnt, 3'b100);
    chk("t3_addr2", i0.mem_addr, 16'h0200);
    i0.req = 3'b001;
    @(negedge clk);
    @(negedge clk);
    chk("t3_ack2", i0.ack, 3'b100);
    @(negedge clk);
    @(negedge clk);
    chk("t3_regnt0", i0.gnt, 3'b001);
    i0.req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    chk("t3_ack0b", i0.ack, 3'b001);
    @(negedge clk);

    // Test 4: all three requesters held for six accesses, starting from reset
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
`ifdef MEM_ARB_RR_EN
    exp_order = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
`else
    exp_order = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b001, 3'b010};
`endif
    i0.req = 3'b111; i0.req_we = 3'b000;
    for (int a = 0; a < 6; a++) begin
      for (int n = 0; n < 8 && i0.gnt == 3'b000; n++) @(negedge clk);
      chk("t4_gnt", i0.gnt, exp_order[a]);
      chk("t4_onehot", $onehot0(i0.gnt), 1'b1);
      for (int n = 0; n < 8 && i0.ack == 3'b000; n++) @(negedge clk);
      chk("t4_ack", i0.ack, exp_order[a]);
      @(negedge clk);
    end
    i0.req = 3'b000;
    repeat (4) @(negedge clk);

    // Test 5: init during the last cycle of a write access
    i0.req = 3'b011; i0.req_we = 3'b011;
    i0.req_addr = {16'h0000, 16'h0000, 16'hA000};
    i0.req_wdata = {16'h0000, 16'h0000, 16'h5A5A};
    @(negedge clk);
    chk("t5_gnt0", i0.gnt, 3'b001);
    chk("t5_we_c1", i0.mem_we, 1'b1);
    @(negedge clk);
    chk("t5_wdata_c2", i0.mem_wdata, 16'h5A5A);
    init = 1'b1;
    @(negedge clk);
    chk("t5_en_abort", i0.mem_en, 1'b0);
    chk("t5_we_abort", i0.mem_we, 1'b0);
    chk("t5_gnt_abort", i0.gnt, 3'b000);
    chk("t5_ack_abort", i0.ack, 3'b000);
    init = 1'b0;
    i0.req = 3'b010; i0.req_we = 3'b000;
    @(negedge clk);
    chk("t5_gnt1", i0.gnt, 3'b010);
    chk("t5_no_ack0", i0.ack, 3'b000);
    i0.req = 3'b000;
    @(negedge clk);
    @(negedge clk);
    chk("t5_ack1", i0.ack, 3'b010);
    @(negedge clk);

    // Test 6: MEM_WAIT=0 read by requester 2, with its req dropped during ACCESS
    i1.req = 3'b100; i1.req_we = 3'b000;
    i1.req_addr = {16'h0300, 16'h0000, 16'h0000};
    i1.mem_rdata = 16'hC0DE;
    @(negedge clk);
    i1.req = 3'b000;
    chk("t6_gnt", i1.gnt, 3'b100);
    chk("t6_en", i1.mem_en, 1'b1);
    chk("t6_addr", i1.mem_addr, 16'h0300);
    @(negedge clk);
    chk("t6_ack", i1.ack, 3'b100);
    chk("t6_en_off", i1.mem_en, 1'b0);
    chk("t6_rdata", i1.rdata, 16'hC0DE);
    @(negedge clk);
    chk("t6_ack_off", i1.ack, 3'b000);
    chk("t6_busy_off", i1.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
